// File: rtl/food_gen_if.sv
// Food handshake between food_gen (master) and the snake core (slave).
// gen_fail is present only when FOOD_GEN_LIMIT_EN is defined.
interface food_gen_if #(
   parameter int MAX_LEN = 64
);
   // get_food is a level sampled every clk, acted on only in IDLE while running;
   // food_valid=1 means food_x/food_y are settled; busy=1 while a cell is being searched.
   logic [1:0]           game_state;
   logic                 get_food;
   logic [5*MAX_LEN-1:0] snake_x_1dim;
   logic [5*MAX_LEN-1:0] snake_y_1dim;
   logic [5:0]           snake_length;
   logic [4:0]           food_x;
   logic [4:0]           food_y;
   logic                 food_valid;
   logic                 busy;
`ifdef FOOD_GEN_LIMIT_EN
   logic                 gen_fail;
`endif

   modport master (
      input  game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length,
      output food_x, food_y, food_valid, busy
`ifdef FOOD_GEN_LIMIT_EN
      , output gen_fail
`endif
   );

   modport slave (
      output game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length,
      input  food_x, food_y, food_valid, busy
`ifdef FOOD_GEN_LIMIT_EN
      , input gen_fail
`endif
   );
endinterface

// File: rtl/food_gen.sv
// Food placer: draws LFSR cells and scans the live snake body one segment per cycle.
// Define FOOD_GEN_LIMIT_EN to bound attempts at 255 and add the gen_fail pulse.
module food_gen #(
   parameter int unsigned GRID_X = 32,
   parameter int unsigned GRID_Y = 24,
   parameter int unsigned INIT_X = 20,
   parameter int unsigned INIT_Y = 20,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   food_gen_if.master  bus,
   output logic [1:0]  state_dbg,
   output logic [15:0] lfsr_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [4:0]  INIT_X5  = INIT_X[4:0];
   localparam logic [4:0]  INIT_Y5  = INIT_Y[4:0];

   state_t      state;
   logic [15:0] lfsr;
   logic        fb;
   logic [4:0]  gx, gy, cx, cy;
   logic [5:0]  idx;
   logic [4:0]  seg_x, seg_y;
   logic        in_range, seg_hit, past, last, give_up;

   assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign gx       = lfsr[4:0];
   assign gy       = lfsr[12:8];
   assign in_range = ({27'd0, gx} < GRID_X) && ({27'd0, gy} < GRID_Y);

   // Body buses are read live; movement during a scan is accepted.
   assign seg_x    = bus.snake_x_1dim[9'(idx) * 9'd5 +: 5];
   assign seg_y    = bus.snake_y_1dim[9'(idx) * 9'd5 +: 5];
   assign seg_hit  = (seg_x == cx) && (seg_y == cy);
   assign past     = (idx >= bus.snake_length);
   assign last     = (idx == bus.snake_length - 6'd1);

`ifdef FOOD_GEN_LIMIT_EN
   logic [7:0] attempts;
   logic       reject;
   assign reject  = ((state == GEN) && !in_range) || ((state == CHECK) && !past && seg_hit);
   assign give_up = reject && (attempts == 8'd254);
`else
   assign give_up = 1'b0;
`endif

   assign state_dbg = state;
   assign lfsr_dbg  = lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         lfsr           <= SEED_EFF;
         bus.food_x     <= INIT_X5;
         bus.food_y     <= INIT_Y5;
         bus.food_valid <= 1'b1;
         bus.busy       <= 1'b0;
         idx            <= 6'd0;
         cx             <= 5'd0;
         cy             <= 5'd0;
      end else begin
         lfsr <= {lfsr[14:0], fb};
         if (bus.game_state == 2'b10) begin
            state          <= IDLE;
            bus.food_x     <= INIT_X5;
            bus.food_y     <= INIT_Y5;
            bus.food_valid <= 1'b1;
            bus.busy       <= 1'b0;
            idx            <= 6'd0;
         end else if (give_up) begin
            state          <= IDLE;
            bus.food_valid <= 1'b0;
            bus.busy       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.get_food && bus.game_state == 2'b00) begin
                     state          <= GEN;
                     bus.busy       <= 1'b1;
                     bus.food_valid <= 1'b0;
                  end
               end
               GEN: begin
                  if (in_range) begin
                     cx    <= gx;
                     cy    <= gy;
                     idx   <= 6'd0;
                     state <= (bus.snake_length == 6'd0) ? DONE : CHECK;
                  end
               end
               CHECK: begin
                  // A shrinking body can leave idx beyond the live length; treat as clear.
                  if (past)         state <= DONE;
                  else if (seg_hit) state <= GEN;
                  else if (last)    state <= DONE;
                  else              idx   <= idx + 6'd1;
               end
               DONE: begin
                  bus.food_x     <= cx;
                  bus.food_y     <= cy;
                  bus.food_valid <= 1'b1;
                  bus.busy       <= 1'b0;
                  state          <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
`ifdef FOOD_GEN_LIMIT_EN
      end
      if (rst) begin
         attempts     <= 8'd0;
         bus.gen_fail <= 1'b0;
      end else begin
         bus.gen_fail <= give_up && (bus.game_state != 2'b10);
         if (state == IDLE)  attempts <= 8'd0;
         else if (reject)    attempts <= attempts + 8'd1;
`endif
      end
   end
endmodule

// File: tb/tb_food_gen.sv
// Directed bench for food_gen: reset, placement, collision retry, busy filtering, init abort.
module tb_food_gen;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  state_dbg;
   logic [15:0] lfsr_dbg;
   logic [15:0] m_lfsr;
   logic [4:0]  bx [64];
   logic [4:0]  by [64];
   int          total = 0;
   int          bad = 0;

   food_gen_if bus ();

   food_gen #(.SEED(SEED)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg),
      .lfsr_dbg  (lfsr_dbg)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.snake_x_1dim = '0;
      bus.snake_y_1dim = '0;
      for (int i = 0; i < 64; i++) begin
         bus.snake_x_1dim[5*i +: 5] = bx[i];
         bus.snake_y_1dim[5*i +: 5] = by[i];
      end
   end

   function automatic logic [15:0] step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk) m_lfsr <= rst ? SEED : step(m_lfsr);

   // Edges after the get_food edge until food_valid, plus the placed cell.
   function automatic void predict(input logic [15:0] v0, input int len, output int cyc,
                                   output logic [4:0] px, output logic [4:0] py);
      logic [15:0] v;
      logic [4:0]  x, y;
      int          c, hit;
      v = v0; c = 1; cyc = -1; px = '0; py = '0;
      for (int n = 0; n < 1000; n++) begin
         x = v[4:0];
         y = v[12:8];
         if (y >= 5'd24) begin
            c++;
            v = step(v);
         end else begin
            hit = -1;
            for (int k = 0; k < len; k++) if (hit < 0 && bx[k] == x && by[k] == y) hit = k;
            if (hit < 0) begin
               cyc = c + len + 1; px = x; py = y;
               return;
            end
            c += hit + 2;
            for (int j = 0; j < hit + 2; j++) v = step(v);
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_body();
      for (int i = 0; i < 64; i++) begin
         bx[i] = 5'd31;
         by[i] = 5'd31;
      end
   endtask

   // One get_food pulse; collide plants the first in-range candidate as segment 2.
   task automatic run_gen(input string tag, input int len, input bit collide, input bit pause);
      logic [15:0] v, w;
      logic [4:0]  px, py;
      int          cyc, c, r;
      @(negedge clk);
      bus.snake_length = 6'(len);
      bus.get_food = 1'b1;
      @(posedge clk); #1;
      bus.get_food = 1'b0;
      if (pause) bus.game_state = 2'b01;
      v = m_lfsr;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_nvalid"}, 32'(bus.food_valid), 32'd0);
      r = 0;
      if (collide) begin
         w = v;
         while (w[12:8] >= 5'd24 && r < 500) begin w = step(w); r++; end
         bx[2] = w[4:0];        by[2] = w[12:8];
         bx[0] = w[4:0] ^ 5'd1; by[0] = w[12:8];
         bx[1] = w[4:0] ^ 5'd2; by[1] = w[12:8];
         bx[3] = w[4:0] ^ 5'd3; by[3] = w[12:8];
      end
      predict(v, len, cyc, px, py);
      c = 0;
      while (bus.food_valid !== 1'b1 && c < 400) begin
         @(posedge clk); #1;
         c++;
         if (collide && c == r + 1) check({tag, "_in_check"}, 32'(state_dbg), 32'd2);
         if (collide && c == r + 4) check({tag, "_retry_gen"}, 32'(state_dbg), 32'd1);
      end
      check({tag, "_latency"}, 32'(c), 32'(cyc));
      check({tag, "_fx"}, 32'(bus.food_x), 32'(px));
      check({tag, "_fy"}, 32'(bus.food_y), 32'(py));
      check({tag, "_y_range"}, 32'(bus.food_y < 5'd24), 32'd1);
      check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
      for (int k = 0; k < len; k++)
         check({tag, "_free"}, 32'(bus.food_x == bx[k] && bus.food_y == by[k]), 32'd0);
      bus.game_state = 2'b00;
   endtask

   initial begin
      int c, gens;
      logic prev;
      bus.game_state   = 2'b00;
      bus.get_food     = 1'b0;
      bus.snake_length = 6'd0;
      clear_body();

      // Clock/reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_fx", 32'(bus.food_x), 32'd20);
      check("rst_fy", 32'(bus.food_y), 32'd20);
      check("rst_valid", 32'(bus.food_valid), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_lfsr", 32'(lfsr_dbg), 32'(16'hACE1));
      @(negedge clk);
      rst = 1'b0;

      // Length-1 snake at (3,3)
      bx[0] = 5'd3; by[0] = 5'd3;
      run_gen("len1", 1, 1'b0, 1'b0);

      // Empty body: shortest path
      run_gen("len0", 0, 1'b0, 1'b0);

      // Forced collision against segment 2 of a length-4 body
      clear_body();
      run_gen("coll", 4, 1'b1, 1'b0);

      // Paused mid-generation still completes
      clear_body();
      bx[0] = 5'd3; by[0] = 5'd3;
      run_gen("pause", 1, 1'b0, 1'b1);

      // get_food while paused is ignored
      @(negedge clk);
      bus.game_state = 2'b01;
      bus.get_food = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("paused_ignore_busy", 32'(bus.busy), 32'd0);
      check("paused_ignore_valid", 32'(bus.food_valid), 32'd1);
      @(negedge clk);
      bus.get_food = 1'b0;
      bus.game_state = 2'b00;

      // Held get_food with a long body: exactly one generation, busy pulse ignored
      for (int i = 0; i < 20; i++) begin bx[i] = 5'(i); by[i] = 5'd23; end
      bus.snake_length = 6'd20;
      gens = 0; prev = 1'b0;
      @(negedge clk);
      bus.get_food = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.busy && !prev) gens++;
         prev = bus.busy;
      end
      bus.get_food = 1'b0;
      @(negedge clk); bus.get_food = 1'b1;
      @(negedge clk); bus.get_food = 1'b0;
      c = 0;
      while (bus.food_valid !== 1'b1 && c < 400) begin
         @(posedge clk); #1;
         if (bus.busy && !prev) gens++;
         prev = bus.busy;
         c++;
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.busy && !prev) gens++;
         prev = bus.busy;
      end
      check("held_one_gen", 32'(gens), 32'd1);
      check("held_idle_busy", 32'(bus.busy), 32'd0);
      check("held_idle_valid", 32'(bus.food_valid), 32'd1);

      // Still-high get_food after completion starts a second generation
      clear_body();
      bx[0] = 5'd3; by[0] = 5'd3;
      bus.snake_length = 6'd1;
      @(negedge clk);
      bus.get_food = 1'b1;
      @(posedge clk); #1;
      c = 0;
      while (bus.food_valid !== 1'b1 && c < 400) begin @(posedge clk); #1; c++; end
      check("rehold_first_done", 32'(bus.food_valid), 32'd1);
      @(posedge clk); #1;
      check("rehold_restart_busy", 32'(bus.busy), 32'd1);
      check("rehold_restart_state", 32'(state_dbg), 32'd1);
      bus.get_food = 1'b0;
      c = 0;
      while (bus.food_valid !== 1'b1 && c < 400) begin @(posedge clk); #1; c++; end
      check("rehold_second_done", 32'(bus.food_valid), 32'd1);

      // Init during CHECK aborts to the initial food
      for (int i = 0; i < 20; i++) begin bx[i] = 5'(i); by[i] = 5'd23; end
      bus.snake_length = 6'd20;
      @(negedge clk);
      bus.get_food = 1'b1;
      @(posedge clk); #1;
      bus.get_food = 1'b0;
      c = 0;
      while (state_dbg !== 2'd2 && c < 400) begin @(posedge clk); #1; c++; end
      check("init_reached_check", 32'(state_dbg), 32'd2);
      @(negedge clk);
      bus.game_state = 2'b10;
      @(posedge clk); #1;
      check("init_fx", 32'(bus.food_x), 32'd20);
      check("init_fy", 32'(bus.food_y), 32'd20);
      check("init_valid", 32'(bus.food_valid), 32'd1);
      check("init_busy", 32'(bus.busy), 32'd0);
      check("init_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
      bus.get_food = 1'b1;
      @(posedge clk); #1;
      check("init_ignores_get_food", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.get_food = 1'b0;
      bus.game_state = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
